// File: rtl/dff_mem_eshaanmehta_if.sv
// Tile-side signal bundle for the 64 x 8 flip-flop RAM: enable, address/control,
// write data in, and the read-data / output-enable returns.
interface dff_mem_eshaanmehta_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/dff_mem_eshaanmehta.sv
// 64 x 8 single-port RAM built from plain flops, packaged as a TinyTapeout tile.
// ui_in[5:0] = addr, ui_in[6] = chip enable, ui_in[7] = lr_n (0 write, 1 read).
// Read data is registered and mirrored on uo_out and uio_out.
module dff_mem_eshaanmehta (
   input  logic                      clk,
   input  logic                      rst_n,
   dff_mem_eshaanmehta_if.slave      bus
);

   logic [7:0] mem [0:63];
   logic [7:0] rdata;
   logic [5:0] addr;
   logic       acc;
   logic       lr_n;

   assign addr = bus.ui_in[5:0];
   assign acc  = bus.ena & bus.ui_in[6];
   assign lr_n = bus.ui_in[7];

   // Storage array: cleared by reset, written on a qualified load cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) begin
            mem[i] <= 8'h00;
         end
      end else if (acc && !lr_n) begin
         mem[addr] <= bus.uio_in;
      end
   end

   // Read register: updates only on a qualified read, otherwise holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= 8'h00;
      end else if (acc && lr_n) begin
         rdata <= mem[addr];
      end
   end

   assign bus.uo_out  = rdata;
   assign bus.uio_out = rdata;
   // The bidir pins drive only during an active read so write data on uio_in
   // is never contended; rst_n gating keeps them released while in reset.
   assign bus.uio_oe  = (rst_n && acc && lr_n) ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_dff_mem_eshaanmehta.sv
// Scoreboard bench for the 64 x 8 flop RAM tile: read tasks push hand-computed
// expected data, an independent monitor pops and checks after each read edge.
module tb_dff_mem_eshaanmehta;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   logic [7:0] sb [$];

   dff_mem_eshaanmehta_if bus ();

   dff_mem_eshaanmehta dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Monitor: any edge that performs a read must match the scoreboard head.
   initial begin
      logic       fire;
      logic [7:0] e;
      forever begin
         @(posedge clk);
         fire = rst_n && bus.ena && bus.ui_in[6] && bus.ui_in[7];
         #1;
         if (fire) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_read: got %02h expected no read", bus.uo_out);
            end else begin
               e = sb.pop_front();
               chk("rd_uo_out", bus.uo_out, e);
               chk("rd_uio_out", bus.uio_out, e);
            end
         end
      end
   end

   task automatic wr(input logic [5:0] a, input logic [7:0] d,
                     input logic en = 1'b1, input logic ena = 1'b1);
      @(negedge clk);
      bus.ena    = ena;
      bus.ui_in  = {1'b0, en, a};
      bus.uio_in = d;
      #1 chk("wr_uio_oe", bus.uio_oe, 8'h00);
   endtask

   task automatic rd(input logic [5:0] a, input logic [7:0] exp);
      @(negedge clk);
      bus.ena   = 1'b1;
      bus.ui_in = {2'b11, a};
      sb.push_back(exp);
      #1 chk("rd_uio_oe", bus.uio_oe, 8'hFF);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.ena   = 1'b1;
      bus.ui_in = 8'h00;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held for two cycles with a read pattern presented: oe must stay low.
      rst_n      = 1'b0;
      bus.ena    = 1'b1;
      bus.ui_in  = 8'hC5;
      bus.uio_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_uo_out", bus.uo_out, 8'h00);
      chk("rst_uio_out", bus.uio_out, 8'h00);
      chk("rst_uio_oe", bus.uio_oe, 8'h00);
      @(negedge clk);
      bus.ui_in = 8'h00;
      rst_n     = 1'b1;
      rd(6'h05, 8'h00);

      // Basic write then read of address 1.
      wr(6'h01, 8'hAA);
      rd(6'h01, 8'hAA);

      // Hold: a write must not disturb the read register.
      wr(6'h03, 8'h33);
      @(posedge clk);
      #1 chk("hold_during_wr", bus.uo_out, 8'hAA);
      idle();
      @(posedge clk);
      #1 chk("hold_after_wr", bus.uo_out, 8'hAA);
      rd(6'h03, 8'h33);

      // Enable gating: chip enable low blocks the write.
      wr(6'h02, 8'h55, 1'b0, 1'b1);
      rd(6'h02, 8'h00);
      rd(6'h03, 8'h33);
      // Tile enable low blocks both the write and the read-register update.
      wr(6'h02, 8'h55, 1'b1, 1'b0);
      @(negedge clk);
      bus.ena   = 1'b0;
      bus.ui_in = {2'b11, 6'h02};
      #1 chk("ena0_uio_oe", bus.uio_oe, 8'h00);
      @(posedge clk);
      #1 chk("ena0_rdata_hold", bus.uo_out, 8'h33);
      rd(6'h02, 8'h00);

      // Address independence: fill every word with its own address, read back.
      for (int i = 0; i < 64; i++) wr(i[5:0], i[7:0]);
      for (int i = 0; i < 64; i++) rd(i[5:0], i[7:0]);
      rd(6'h3F, 8'h3F);

      // Reset mid-operation clears outputs at once and wipes the array.
      wr(6'h07, 8'hC3);
      rd(6'h07, 8'hC3);
      idle();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_uo_out", bus.uo_out, 8'h00);
      chk("midrst_uio_out", bus.uio_out, 8'h00);
      chk("midrst_uio_oe", bus.uio_oe, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      rd(6'h07, 8'h00);
      rd(6'h3F, 8'h00);
      idle();

      for (int n = 0; n < 10 && sb.size() != 0; n++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
